// File: rtl/data_memory_responder_if.sv
// Requester <-> data memory responder bus.
//   req_i   : requester asks for a transfer
//   we_i    : 1 = store, 0 = load
//   addr_i  : byte address
//   wdata_i : store data
//   be_i    : store byte enables, be_i[n] covers wdata_i[8n+7:8n]
//   ack_o   : one-cycle response strobe
//   rdata_o : load data, valid with ack_o
//   err_o   : transfer rejected, valid with ack_o
//   busy_o  : responder is in WAIT or RESP
interface data_memory_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        busy_o;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i,
        output ack_o, rdata_o, err_o, busy_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i,
        input  ack_o, rdata_o, err_o, busy_o
    );
endinterface

// File: rtl/data_memory_responder.sv
// Word-organised data memory with a fixed-latency request/ack protocol.
// A request is captured in IDLE, held for WAIT_CYCLES wait states, then
// answered with a single-cycle ack_o carrying rdata_o/err_o. Stores land in
// memory at the edge that ends the ack cycle, and only for enabled bytes.
//   clk_i : single clock, rising edge
//   rst_i : asynchronous active-low reset (memory contents are kept)
//   bus   : data_memory_responder_if slave modport
//
// state | meaning
// IDLE  | waiting for req_i; captures the request when it arrives
// WAIT  | counting wait states, bus inputs ignored
// RESP  | ack_o high for this one cycle, store commits at its end
module data_memory_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    data_memory_responder_if.slave    bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // Down-counter preload: WAIT is left on the edge where the count is zero,
    // so WAIT_CYCLES wait states need a preload of WAIT_CYCLES-1.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;
    logic        ack_q;
    logic        err_q;
    logic        busy_q;
    logic [31:0] rdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] resp_addr;
    logic        resp_we;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_we;

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS));
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return a[AW+1:2];
    endfunction

    // With zero wait states the response is formed on the accept edge itself,
    // so the live bus inputs stand in for the not-yet-captured request.
    always_comb begin
        resp_addr = cap_addr;
        resp_we   = cap_we;
        if (state == IDLE) begin
            resp_addr = bus.addr_i;
            resp_we   = bus.we_i;
        end
        resp_err   = addr_err(resp_addr);
        resp_rdata = 32'd0;
        if (!resp_we && !resp_err) begin
            resp_rdata = mem[word_idx(resp_addr)];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            cap_we    <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            cap_be    <= 4'd0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_i) begin
                        cap_we    <= bus.we_i;
                        cap_addr  <= bus.addr_i;
                        cap_wdata <= bus.wdata_i;
                        cap_be    <= bus.be_i;
                        busy_q    <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state   <= RESP;
                            ack_q   <= 1'b1;
                            err_q   <= resp_err;
                            rdata_q <= resp_rdata;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state   <= RESP;
                        ack_q   <= 1'b1;
                        err_q   <= resp_err;
                        rdata_q <= resp_rdata;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= 32'd0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= 32'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // err_q holds the captured transfer's error flag throughout RESP.
    // A reset during WAIT/RESP forces IDLE asynchronously, so no write follows.
    assign mem_we = (state == RESP) && cap_we && !err_q;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (cap_be[b]) begin
                    mem[word_idx(cap_addr)][8*b +: 8] <= cap_wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.ack_o   = ack_q;
    assign bus.err_o   = err_q;
    assign bus.rdata_o = rdata_q;
    assign bus.busy_o  = busy_q;

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored (power of two, 4..4096).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted before each response (0..15).
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_i  input  1  requester asks for a transfer.
REQ-006 SHALL have port we_i  input  1  1 = store, 0 = load.
REQ-007 SHALL have port addr_i  input  32  byte address.
REQ-008 SHALL have port wdata_i  input  32  store data.
REQ-009 SHALL have port be_i  input  4  store byte enables; be_i[n] enables wdata_i[8n+7:8n].
REQ-010 SHALL have port ack_o  output  1  one-cycle response strobe.
REQ-011 SHALL have port rdata_o  output  32  load data, valid while ack_o=1.
REQ-012 SHALL have port err_o  output  1  transfer rejected, valid while ack_o=1.
REQ-013 SHALL have port busy_o  output  1  high in WAIT and RESP states.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 In IDLE with req_i=1, SHALL capture addr_i, we_i, wdata_i, be_i at the rising edge and go to WAIT; if WAIT_CYCLES=0, go directly to RESP.
REQ-016 In IDLE with req_i=0, SHALL stay in IDLE.
REQ-017 In WAIT, SHALL count WAIT_CYCLES cycles with a 4-bit counter, then go to RESP.
REQ-018 Within WAIT, req_i and all other inputs SHALL be ignored.
REQ-019 Latency: for a request accepted at edge k, ack_o SHALL be high for exactly the cycle after edge k+WAIT_CYCLES, i.e. the cycle following edge k when WAIT_CYCLES=0.
REQ-020 In RESP, SHALL assert ack_o for exactly one cycle, then return to IDLE.
REQ-021 req_i during RESP SHALL be ignored.
REQ-022 Requester SHALL deassert req_i on the edge ending the ack_o cycle; a req_i still high in the following IDLE cycle SHALL be accepted as a new transfer.
REQ-023 Error condition: captured addr[1:0]!=0 or captured addr[31:2] >= DEPTH_WORDS.
REQ-024 On an error transfer, SHALL assert err_o=1 with ack_o, drive rdata_o=0 and leave memory unchanged.
REQ-025 Load, no error: rdata_o SHALL equal mem[addr[31:2]] during the ack_o cycle; err_o=0.
REQ-026 Store, no error: SHALL write only enabled bytes of mem[addr[31:2]] at the edge ending the RESP cycle; rdata_o=0, err_o=0.
REQ-027 Store with be_i=0000 SHALL be acknowledged with no memory change.
REQ-028 Outside the ack_o cycle, rdata_o and err_o SHALL be 0.
REQ-029 Back-to-back transfers to the same word: a load accepted after a store's ack SHALL return the stored data.

Reset
REQ-030 While rst_i=0: state IDLE, counter 0, ack_o=0, err_o=0, rdata_o=0, busy_o=0, captured request cleared.
REQ-031 Assertion of rst_i in WAIT or RESP SHALL abort the transfer with no ack_o and no memory write.
REQ-032 Memory contents SHALL not be cleared by reset.
REQ-033 First request SHALL be accepted at the first rising edge with rst_i=1 and req_i=1.

Verification
REQ-034 WAIT_CYCLES=2, store addr 0x10, wdata 0xDEADBEEF, be 1111, then load addr 0x10 -> ack_o 3 cycles after each accept; load rdata_o=0xDEADBEEF, err_o=0.
REQ-035 Store 0x11223344 to 0x20 with be 1111, then store 0xAABBCCDD with be 0101, then load 0x20 -> rdata_o=0x11BB33DD.
REQ-036 Load addr 0x22 (misaligned), and load addr 4*DEPTH_WORDS -> each acked with err_o=1, rdata_o=0; a prior value at 0x20 is unchanged on reload.
REQ-037 WAIT_CYCLES=0, req_i held high for 4 cycles with loads -> ack_o high in cycles 2 and 4 only, busy_o high in those same cycles.
REQ-038 Store 0x0 to 0x30, then accept a store 0xFFFFFFFF to 0x30, drive rst_i=0 during WAIT, release, load 0x30 -> no ack for the aborted store; rdata_o=0x00000000.
REQ-039 req_i toggled during WAIT with different addr_i -> response uses the address captured at accept; no extra ack_o.
